clk_div_mc: RTL and testbench

CLK_DIV_MC -- requirements
Module: clk_div_mc

---
 rtl/clk_div_mc.sv | 124 ++++++++++++
 tb/tb_clk_div_mc.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_mc.sv
// clk_div_mc: multi-channel programmable clock divider with lock qualification.
//
// Each channel produces a registered 50%-duty clock of period 2*(div+1)
// clkin cycles, plus one-cycle rise/fall strobes registered with it.
// New divide values are staged in a pending register and only take effect
// at a rising edge of that channel's clkout (or immediately while the
// channel is stopped), so a running output never sees a truncated half.
//
// Ports
//   clkin        in   sole clock, rising edge
//   reset        in   asynchronous, active-high
//   div_val      in   NUM_CH*CNT_W  divide value, channel i at [i*CNT_W +: CNT_W]
//   div_load     in   NUM_CH        strobe: capture div_val slice as pending
//   ch_en        in   NUM_CH        channel run enable
//   clkout       out  NUM_CH        divided clocks
//   clkout_rise  out  NUM_CH        high in the cycle clkout becomes 1
//   clkout_fall  out  NUM_CH        high in the cycle clkout becomes 0
//   busy         out  NUM_CH        pending value waiting to be applied
//   lock         out  1             outputs valid; sticky until reset
module clk_div_mc #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 16,
  parameter int DEFAULT_DIV = 1,
  parameter int LOCK_CYCLES = 64
) (
  input  logic                      clkin,
  input  logic                      reset,
  input  logic [NUM_CH*CNT_W-1:0]   div_val,
  input  logic [NUM_CH-1:0]         div_load,
  input  logic [NUM_CH-1:0]         ch_en,
  output logic [NUM_CH-1:0]         clkout,
  output logic [NUM_CH-1:0]         clkout_rise,
  output logic [NUM_CH-1:0]         clkout_fall,
  output logic [NUM_CH-1:0]         busy,
  output logic                      lock
);

  localparam int LCK_W = $clog2(LOCK_CYCLES + 1);

  logic [LCK_W-1:0] lock_cnt;

  // Counter freezes once lock is reached; lock rises on the
  // LOCK_CYCLES-th edge after reset release.
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      lock_cnt <= '0;
      lock     <= 1'b0;
    end else if (!lock) begin
      lock_cnt <= lock_cnt + 1'b1;
      if (lock_cnt == LCK_W'(LOCK_CYCLES - 1))
        lock <= 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] active_div;
    logic [CNT_W-1:0] pending_div;
    logic             pend;
    logic             clk_q;
    logic             rise_q;
    logic             fall_q;
    logic             stopped;
    logic             run;
    logic             tc;
    logic             rise_now;
    logic             fall_now;
    logic             apply;

    // A disabled channel keeps running until its high half has finished,
    // so "stopped" requires the output to already be low.
    assign stopped  = !ch_en[i] && !clk_q;
    assign run      = lock && !stopped;
    assign tc       = (cnt == active_div);
    assign rise_now = run && tc && !clk_q;
    assign fall_now = run && tc && clk_q;
    assign apply    = pend && (stopped || rise_now);

    always_ff @(posedge clkin or posedge reset) begin
      if (reset) begin
        cnt         <= '0;
        active_div  <= CNT_W'(DEFAULT_DIV);
        pending_div <= CNT_W'(DEFAULT_DIV);
        pend        <= 1'b0;
        clk_q       <= 1'b0;
        rise_q      <= 1'b0;
        fall_q      <= 1'b0;
      end else begin
        rise_q <= rise_now;
        fall_q <= fall_now;

        if (run) begin
          if (tc) begin
            cnt   <= '0;
            clk_q <= !clk_q;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end else begin
          cnt   <= '0;
          clk_q <= 1'b0;
        end

        // Apply uses the value pending before this edge; a load on the
        // same edge becomes the next pending value and keeps pend set.
        if (apply)
          active_div <= pending_div;

        if (div_load[i]) begin
          pending_div <= div_val[i*CNT_W +: CNT_W];
          pend        <= 1'b1;
        end else if (apply) begin
          pend <= 1'b0;
        end
      end
    end

    assign clkout[i]      = clk_q;
    assign clkout_rise[i] = rise_q;
    assign clkout_fall[i] = fall_q;
    assign busy[i]        = pend;
  end

endmodule

// File: tb/tb_clk_div_mc.sv
// Testbench for clk_div_mc: randomized and directed stimulus, scoreboard
// queue filled by the driver from a half-period reference model, drained
// and compared by an independent monitor.
module tb_clk_div_mc;
  localparam int NUM_CH      = 4;
  localparam int CNT_W       = 16;
  localparam int DEFAULT_DIV = 1;
  localparam int LOCK_CYCLES = 64;

  logic                    clkin = 1'b0;
  logic                    reset;
  logic [NUM_CH*CNT_W-1:0] div_val;
  logic [NUM_CH-1:0]       div_load;
  logic [NUM_CH-1:0]       ch_en;
  logic [NUM_CH-1:0]       clkout, clkout_rise, clkout_fall, busy;
  logic                    lock;

  clk_div_mc #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEFAULT_DIV(DEFAULT_DIV), .LOCK_CYCLES(LOCK_CYCLES)
  ) dut (
    .clkin(clkin), .reset(reset), .div_val(div_val), .div_load(div_load),
    .ch_en(ch_en), .clkout(clkout), .clkout_rise(clkout_rise),
    .clkout_fall(clkout_fall), .busy(busy), .lock(lock)
  );

  always #5 clkin = ~clkin;

  typedef struct {
    logic [NUM_CH-1:0] clkout;
    logic [NUM_CH-1:0] rise;
    logic [NUM_CH-1:0] fall;
    logic [NUM_CH-1:0] busy;
    logic              lock;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: each channel tracks the cycles left in its current
  // half period (-1 = not started) rather than an up-counter.
  int m_left [NUM_CH];
  bit m_lvl  [NUM_CH];
  int m_act  [NUM_CH];
  int m_pv   [NUM_CH];
  bit m_pend [NUM_CH];
  bit m_rise [NUM_CH];
  bit m_fall [NUM_CH];
  bit m_lock;
  int m_rel;
  logic [NUM_CH-1:0] en_r;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_left[i] = -1; m_lvl[i] = 0; m_act[i] = DEFAULT_DIV; m_pv[i] = DEFAULT_DIV;
      m_pend[i] = 0; m_rise[i] = 0; m_fall[i] = 0;
    end
    m_lock = 0; m_rel = 0;
  endfunction

  function automatic void model_step(input logic [NUM_CH-1:0] en, input logic [NUM_CH-1:0] ld,
                                     input logic [NUM_CH*CNT_W-1:0] dv);
    bit ol = m_lock;
    if (!m_lock) begin
      m_rel++;
      if (m_rel == LOCK_CYCLES) m_lock = 1;
    end
    for (int i = 0; i < NUM_CH; i++) begin
      m_rise[i] = 0; m_fall[i] = 0;
      if (!en[i] && !m_lvl[i]) begin
        m_left[i] = -1;
        if (m_pend[i]) begin m_act[i] = m_pv[i]; m_pend[i] = 0; end
      end else if (!ol) begin
        m_left[i] = -1;
      end else begin
        if (m_left[i] < 0) m_left[i] = m_act[i] + 1;
        m_left[i]--;
        if (m_left[i] == 0) begin
          m_lvl[i] = !m_lvl[i];
          if (m_lvl[i]) begin
            m_rise[i] = 1;
            if (m_pend[i]) begin m_act[i] = m_pv[i]; m_pend[i] = 0; end
          end else begin
            m_fall[i] = 1;
          end
          m_left[i] = m_act[i] + 1;
        end
      end
      if (ld[i]) begin m_pv[i] = int'(dv[i*CNT_W +: CNT_W]); m_pend[i] = 1; end
    end
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    for (int i = 0; i < NUM_CH; i++) begin
      e.clkout[i] = m_lvl[i]; e.rise[i] = m_rise[i];
      e.fall[i] = m_fall[i];  e.busy[i] = m_pend[i];
    end
    e.lock = m_lock;
    return e;
  endfunction

  function automatic bit will_rise(input int i);
    int l;
    l = (m_left[i] < 0) ? m_act[i] + 1 : m_left[i];
    return en_r[i] && m_lock && !m_lvl[i] && (l == 1);
  endfunction

  task automatic drive_and_push(input logic [NUM_CH-1:0] ld, input logic [NUM_CH*CNT_W-1:0] dv);
    ch_en = en_r; div_load = ld; div_val = dv;
    model_step(en_r, ld, dv);
    sb.push_back(model_out());
  endtask

  task automatic tick(input logic [NUM_CH-1:0] ld, input logic [NUM_CH*CNT_W-1:0] dv);
    @(negedge clkin);
    drive_and_push(ld, dv);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick('0, '0);
  endtask

  task automatic load1(input int ch, input int v);
    logic [NUM_CH*CNT_W-1:0] dv;
    logic [NUM_CH-1:0] ld;
    dv = '0; ld = '0;
    dv[ch*CNT_W +: CNT_W] = CNT_W'(v);
    ld[ch] = 1'b1;
    tick(ld, dv);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_clkout"}, 32'(clkout), 0);
    chk({tag, "_rise"},   32'(clkout_rise), 0);
    chk({tag, "_fall"},   32'(clkout_fall), 0);
    chk({tag, "_busy"},   32'(busy), 0);
    chk({tag, "_lock"},   32'(lock), 0);
  endtask

  // Monitor: pops one expectation per clock, sampled just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clkin);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("clkout", 32'(clkout),      32'(e.clkout));
        chk("rise",   32'(clkout_rise), 32'(e.rise));
        chk("fall",   32'(clkout_fall), 32'(e.fall));
        chk("busy",   32'(busy),        32'(e.busy));
        chk("lock",   32'(lock),        32'(e.lock));
      end
    end
  end

  initial begin
    logic [NUM_CH-1:0]       ld;
    logic [NUM_CH*CNT_W-1:0] dv;
    int k;

    reset = 1'b1; ch_en = '0; div_load = '0; div_val = '0; en_r = '0;
    model_reset();
    #1;
    check_reset_outputs("por");
    repeat (3) @(posedge clkin);
    #2 reset = 1'b0;

    // Default divide, all channels enabled: lock then period 4.
    en_r = '1;
    idle(80);

    // ch0: stop, load 0 while stopped, restart -> clkin/2.
    en_r[0] = 1'b0;
    idle(6);
    load1(0, 0);
    idle(2);
    en_r[0] = 1'b1;
    idle(12);

    // ch1: div 3, then load 5 during a high half.
    load1(1, 3);
    for (k = 0; k < 40 && !(m_act[1] == 3 && m_lvl[1]); k++) idle(1);
    chk("wait_ch1_high", 32'(m_act[1] == 3 && m_lvl[1]), 1);
    load1(1, 5);
    idle(30);

    // ch2: div 3, drop enable one cycle into the high half.
    load1(2, 3);
    for (k = 0; k < 40 && !(m_act[2] == 3 && m_rise[2]); k++) idle(1);
    chk("wait_ch2_rise", 32'(m_act[2] == 3 && m_rise[2]), 1);
    idle(1);
    en_r[2] = 1'b0;
    idle(12);
    en_r[2] = 1'b1;

    // ch3: pending 2, then load 7 on the very edge that applies it.
    load1(3, 2);
    for (k = 0; k < 40 && !will_rise(3); k++) idle(1);
    chk("wait_ch3_rise", 32'(will_rise(3)), 1);
    load1(3, 7);
    idle(30);

    // Random enables and loads.
    for (int n = 0; n < 600; n++) begin
      ld = '0; dv = '0;
      for (int i = 0; i < NUM_CH; i++) begin
        if ($urandom_range(0, 39) == 0) en_r[i] = ~en_r[i];
        if ($urandom_range(0, 24) == 0) begin
          ld[i] = 1'b1;
          dv[i*CNT_W +: CNT_W] = CNT_W'($urandom_range(0, 5));
        end
      end
      tick(ld, dv);
    end

    // Reset pulse between edges while some output is high.
    en_r = '1;
    for (k = 0; k < 40 && m_lvl[0] == 0; k++) idle(1);
    load1(1, 4);
    @(negedge clkin);
    ch_en = en_r; div_load = '0; div_val = '0;
    #1 reset = 1'b1;
    #1 check_reset_outputs("pulse");
    #1 reset = 1'b0;
    model_reset();
    drive_and_push('0, '0);
    idle(80);

    repeat (2) @(posedge clkin);
    #2;
    chk("sb_drained", 32'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
